// File: rtl/fib_sched_pkg.sv
// Shared types and constants for the Fibonacci-step scheduler.
//   fib_ctx_t   : per-channel context (a, b)
//   fib_resp_t  : registered response (channel, data, wrap)
// ch is sized for the largest supported channel count (8); the top
// narrows it to its own CH_W.
package fib_sched_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned CH_MAX_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } fib_ctx_t;

  localparam fib_ctx_t FIB_CTX_RST = '{a: 8'h00, b: 8'h01};

  typedef struct packed {
    logic [CH_MAX_W-1:0] ch;
    logic [DATA_W-1:0]   data;
    logic                wrap;
  } fib_resp_t;

  localparam fib_resp_t FIB_RESP_RST = '0;

endpackage

// File: rtl/fib_step_sched_rr_pick.sv
// rr_pick: combinational round-robin first-set search.
// Ports:
//   req  in  N  request vector
//   ptr  in  W  index at which the search starts (wraps N-1 -> 0)
//   gnt  out N  one-hot grant (all zero when no request)
//   idx  out W  index of the granted bit (0 when none)
//   any  out 1  some request was found
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    int unsigned pos;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr) + k) % N;
      if (!any && req[pos[W-1:0]]) begin
        any             = 1'b1;
        idx             = pos[W-1:0];
        gnt[pos[W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fib_step_sched.sv
// fib_step_sched: one shared 8-bit Fibonacci-step datapath serving NUM_CH
// requesters, each with a private (a, b) context. An accepted request
// advances its context (a, b) -> (b, a+b mod 256) and produces a registered
// response one cycle later, with valid/ready backpressure.
// Optional build macro FIB_PRIO0_EN: channel 0 gets fixed top priority and
// channels 1..NUM_CH-1 round-robin among themselves.
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   req_valid   per-channel step request
//   req_ready   one-hot accept (at most one bit high)
//   ctx_clr     per-channel context clear; excludes that channel this cycle
//   resp_valid  response register holds a result
//   resp_ready  consumer accepts the response
//   resp_ch     channel that produced the response
//   resp_data   old b of the stepped channel (= its new a)
//   resp_wrap   a+b carried out of 8 bits on that step
//   busy        any request pending or response held
module fib_step_sched
  import fib_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_valid,
  output logic [NUM_CH-1:0] req_ready,
  input  logic [NUM_CH-1:0] ctx_clr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [CH_W-1:0]   resp_ch,
  output logic [7:0]        resp_data,
  output logic              resp_wrap,
  output logic              busy
);

  logic              can_accept;
  logic              fire;
  logic              ptr_upd;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] pick_req;
  logic [NUM_CH-1:0] pick_gnt;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;
  logic [NUM_CH-1:0] win_gnt;
  logic [CH_W-1:0]   win_idx;
  logic              win_any;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   ptr_nxt;
  fib_ctx_t          ctx_q [NUM_CH];
  fib_ctx_t          sel_ctx;
  logic [DATA_W:0]   sum;
  fib_resp_t         resp_q;
  logic              resp_valid_q;

  assign can_accept = ~resp_valid_q | resp_ready;
  // A channel being cleared never competes, so clear beats a same-cycle request.
  assign elig       = req_valid & ~ctx_clr;

`ifdef FIB_PRIO0_EN
  // Channel 0 is kept out of the rotation and overrides it when eligible.
  assign pick_req = {elig[NUM_CH-1:1], 1'b0};

  always_comb begin
    win_gnt = pick_gnt;
    win_idx = pick_idx;
    win_any = pick_any;
    if (elig[0]) begin
      win_gnt = '0;
      win_gnt[0] = 1'b1;
      win_idx = '0;
      win_any = 1'b1;
    end
  end

  assign ptr_upd = fire && (win_idx != '0);
`else
  assign pick_req = elig;
  assign win_gnt  = pick_gnt;
  assign win_idx  = pick_idx;
  assign win_any  = pick_any;
  assign ptr_upd  = fire;
`endif

  rr_pick #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign req_ready = win_gnt & {NUM_CH{can_accept}};
  assign fire      = win_any & can_accept;

  assign sel_ctx = ctx_q[win_idx];
  assign sum     = {1'b0, sel_ctx.a} + {1'b0, sel_ctx.b};
  assign ptr_nxt = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + CH_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ctx_q[i] <= FIB_CTX_RST;
      end
      resp_valid_q <= 1'b0;
      resp_q       <= FIB_RESP_RST;
      ptr_q        <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ctx_clr[i]) begin
          ctx_q[i] <= FIB_CTX_RST;
        end else if (fire && (win_idx == CH_W'(i))) begin
          ctx_q[i] <= '{a: sel_ctx.b, b: sum[DATA_W-1:0]};
        end
      end

      if (fire) begin
        resp_valid_q <= 1'b1;
        resp_q.ch    <= CH_MAX_W'(win_idx);
        resp_q.data  <= sel_ctx.b;
        resp_q.wrap  <= sum[DATA_W];
      end else if (resp_ready) begin
        resp_valid_q <= 1'b0;
      end

      if (ptr_upd) begin
        ptr_q <= ptr_nxt;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_ch    = resp_q.ch[CH_W-1:0];
  assign resp_data  = resp_q.data;
  assign resp_wrap  = resp_q.wrap;
  assign busy       = (|req_valid) | resp_valid_q;

endmodule

// File: tb/tb_fib_step_sched.sv
// Directed, table-driven bench for fib_step_sched (NUM_CH = 4).
// Each table row: inputs for one cycle, the expected req_ready in that
// cycle, and the expected response register after the following edge.
module tb_fib_step_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [3:0] ctx_clr;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_ch;
  logic [7:0] resp_data;
  logic       resp_wrap;
  logic       busy;

  int n_vec;
  int n_err;

  typedef struct {
    logic [3:0] req;
    logic [3:0] clr;
    logic       rr;
    logic [3:0] rdy;
    logic       v;
    logic [1:0] ch;
    logic [7:0] d;
    logic       w;
  } vec_t;

  vec_t tbl[$];

  fib_step_sched #(.NUM_CH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .ctx_clr    (ctx_clr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_ch    (resp_ch),
    .resp_data  (resp_data),
    .resp_wrap  (resp_wrap),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic [3:0] req, input logic [3:0] clr, input logic rr,
                              input logic [3:0] rdy, input logic v, input logic [1:0] ch,
                              input logic [7:0] d, input logic w);
    vec_t t;
    t.req = req; t.clr = clr; t.rr = rr; t.rdy = rdy;
    t.v = v; t.ch = ch; t.d = d; t.w = w;
    tbl.push_back(t);
  endfunction

  task automatic run_table(input string tag);
    foreach (tbl[k]) begin
      @(negedge clk);
      req_valid  = tbl[k].req;
      ctx_clr    = tbl[k].clr;
      resp_ready = tbl[k].rr;
      #1;
      n_vec++;
      chk($sformatf("%s[%0d].req_ready", tag, k), 32'(req_ready), 32'(tbl[k].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].resp_valid", tag, k), 32'(resp_valid), 32'(tbl[k].v));
      chk($sformatf("%s[%0d].resp_ch", tag, k), 32'(resp_ch), 32'(tbl[k].ch));
      chk($sformatf("%s[%0d].resp_data", tag, k), 32'(resp_data), 32'(tbl[k].d));
      chk($sformatf("%s[%0d].resp_wrap", tag, k), 32'(resp_wrap), 32'(tbl[k].w));
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    req_valid  = '0;
    ctx_clr    = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] fib [13];
    fib = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};
    n_vec = 0;
    n_err = 0;

    rst        = 1'b1;
    req_valid  = '0;
    ctx_clr    = '0;
    resp_ready = 1'b0;
    #1;
    n_vec++;
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_ch", 32'(resp_ch), 32'd0);
    chk("rst.resp_data", 32'(resp_data), 32'd0);
    chk("rst.resp_wrap", 32'(resp_wrap), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ch0: five steps, a gap, then one more step reading back ctx0 = (5,8)
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd1, 1'b0);
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd1, 1'b0);
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd2, 1'b0);
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd3, 1'b0);
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd5, 1'b0);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'd5, 1'b0);
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd8, 1'b0);
    // ch2: 13 steps, last one carries (144+233 = 377); then ctx2 = (233,121)
    for (int k = 0; k < 13; k++)
      add(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, fib[k], (k == 12));
    add(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'd121, 1'b1);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'd121, 1'b1);
    run_table("seq");

    // busy from a bare request with the response register empty
    @(negedge clk);
    req_valid = 4'b0100;
    resp_ready = 1'b0;
    #1;
    n_vec++;
    chk("busy.req_only", 32'(busy), 32'd1);
    req_valid = 4'b0000;
    #1;
    chk("busy.idle", 32'(busy), 32'd0);

    do_reset();
`ifndef FIB_PRIO0_EN
    // all four requesting: rotation 0,1,2,3,0,1,2,3, each channel's data 1,1
    for (int k = 0; k < 8; k++)
      add(4'b1111, 4'b0000, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 8'd1, 1'b0);
    // backpressure: ch3 response held, nothing accepted, pointer frozen at 0
    for (int k = 0; k < 3; k++)
      add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 8'd1, 1'b0);
    add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd2, 1'b0);
    add(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 8'd2, 1'b0);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'd2, 1'b0);
    // ch1 (3 steps, ctx (2,3)) cleared while requesting: no accept, restarts at 1
    add(4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 8'd2, 1'b0);
    add(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 8'd1, 1'b0);
    add(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 8'd1, 1'b0);
    // clear of ch2 removes it from arbitration; ch1 wins instead
    add(4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b1, 2'd1, 8'd2, 1'b0);
    add(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'd1, 1'b0);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'd1, 1'b0);
    run_table("rr");
`else
    // channel 0 dominates, then 1..3 rotate among themselves
    add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd1, 1'b0);
    add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd1, 1'b0);
    add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd2, 1'b0);
    add(4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 8'd1, 1'b0);
    add(4'b1110, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'd1, 1'b0);
    add(4'b1110, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'd1, 1'b0);
    add(4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 8'd1, 1'b0);
    for (int k = 0; k < 3; k++)
      add(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 8'd1, 1'b0);
    add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd3, 1'b0);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'd3, 1'b0);
    run_table("prio");
`endif

    // asynchronous reset with a response pending, applied between edges
    @(negedge clk);
    req_valid  = 4'b0001;
    ctx_clr    = 4'b0000;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    chk("arst.pre_valid", 32'(resp_valid), 32'd1);
    req_valid = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.resp_valid", 32'(resp_valid), 32'd0);
    chk("arst.resp_data", 32'(resp_data), 32'd0);
    chk("arst.resp_ch", 32'(resp_ch), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd1, 1'b0);
    add(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'd1, 1'b0);
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd1, 1'b0);
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd2, 1'b0);
    run_table("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
